pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic replacement for the fixed enable/flush stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure is carried by `ready` instead of a global enable. With the skid buffer compiled in, `in_ready` is fully registered, which breaks the combinational stall path across stages.

## Interface
- `WIDTH`, default 64: payload width in bits (stage struct packed to a vector).
- `CLK`  in  1: clock; all state updates on the rising edge.
- `nRST`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous squash of all held entries.
- `in_valid`  in  1: upstream presents a payload.
- `in_ready`  out  1: stage can accept a payload this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: stage presents a payload downstream.
- `out_ready`  in  1: downstream accepts the payload this cycle.
- `out_data`  out  WIDTH: payload presented downstream.
- `occupancy`  out  2: number of held entries (0..2).

## Operation
- Two transfer events are defined:
  - push = `in_valid && in_ready`
  - pop = `out_valid && out_ready`
- Storage is a main register driving `out_data` plus a skid register.
- State machine states: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- `out_valid` = (state != EMPTY). `in_ready` = (state != TWO), taken from a registered flag, not combinational.
- Transitions when `flush` = 0:
  - EMPTY, push: go to ONE; main <= `in_data`.
  - ONE, push and no pop: go to TWO; skid <= `in_data`.
  - ONE, pop and no push: go to EMPTY; main <= 0.
  - ONE, push and pop: stay in ONE; main <= `in_data`.
  - TWO, pop: go to ONE; main <= skid; skid <= 0. Push cannot occur in TWO.
  - Any other combination: hold.
- Flush takes priority over every other event. Next state is EMPTY, main <= 0, skid <= 0. A push or pop occurring in the flush cycle is discarded; the payload is lost and the upstream sees its handshake as completed.
- Ordering is strictly FIFO. Payloads are never duplicated or reordered.
- Stability rule: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_valid` hold unchanged until flush.
- `out_data` = 0 whenever `out_valid` = 0.
- `occupancy` = 0, 1 or 2 for EMPTY, ONE or TWO respectively.

## Timing
- Reset values (asynchronous, immediate on `nRST` low): state EMPTY, main = 0, skid = 0, `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `occupancy` = 0.
- Reset asserted mid-transfer drops all entries, with no partial update.
- Latency is 1 cycle: a payload pushed at edge N is visible on `out_data` after edge N.
- Throughput is 1 payload per cycle when `out_ready` is held at 1.
- `in_ready` falls the cycle after the skid buffer fills. It rises the cycle after a pop from TWO, or after a flush.
- Flush completes in 1 cycle: `out_valid` = 0 and `in_ready` = 1 after the flush edge.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: behaviour as described above. The skid register is present, `in_ready` is registered and `occupancy` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined:
  - There is no skid register and no TWO state.
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - Push and pop in the same cycle still replaces main.
  - `occupancy` ranges 0..1.
  - Flush, reset and stability rules are unchanged.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with `out_ready` = 1: `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its push, with `occupancy` = 1 throughout.
- Push 0xA then 0xB with `out_ready` = 0: `occupancy` goes 1 then 2, `in_ready` = 0, and `out_data` holds 0xA. Raise `out_ready`: output is 0xA, then 0xB, then `out_valid` = 0.
- In state TWO (0xA, 0xB), assert `flush` together with `in_valid` carrying 0xC: next cycle `out_valid` = 0, `out_data` = 0, `occupancy` = 0, `in_ready` = 1, and 0xC never appears at the output.
- Random `in_valid`/`out_ready` over 10k cycles: the output sequence equals the input sequence, and `out_data` never changes while `out_valid && !out_ready`.
- Assert `nRST` low while in TWO between clock edges: outputs go to reset values immediately, with no clock required.
- With `PIPE_STAGE_SKID_EN` undefined: in ONE with `out_ready` = 0, `in_ready` = 0 in the same cycle; with `out_ready` = 1, push 0x5 replaces the popped entry with no bubble.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register with a valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer. It replaces the
// fixed enable/flush stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls
// are expressed by the downstream ready signal instead of a global enable.
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   : main + skid register, in_ready registered,
//                                  occupancy 0..2.
//   PIPE_STAGE_SKID_EN undefined : main register only, in_ready derived
//                                  combinationally from out_ready,
//                                  occupancy 0..1.
//
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   flush      in   synchronous squash of every held entry
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts a payload this cycle
//   in_data    in   upstream payload [WIDTH-1:0]
//   out_valid  out  stage presents out_data
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload presented downstream (0 when out_valid = 0)
//   occupancy  out  number of held entries
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

`ifdef PIPE_STAGE_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             push, pop;

`ifdef PIPE_STAGE_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;

   // Registered ready: computed from the next state so it is already correct
   // in the cycle the skid fills or drains.
   assign in_ready = in_ready_q;
`else
   // Without a skid slot the stage can only take a new payload when it is
   // empty or its current payload leaves in the same cycle.
   assign in_ready = (state_q == EMPTY) || out_ready;
`endif

   assign out_valid = (state_q != EMPTY);
   // main_q is cleared whenever the stage empties, so out_data is 0 when idle.
   assign out_data  = main_q;
   assign occupancy = 2'(state_q);

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // ---- next-state / datapath selection ----
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         // Flush wins over any handshake in the same cycle.
         state_d = EMPTY;
         main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_d  = '0;
`endif
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
                  main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
               end else if (push) begin
                  state_d = TWO;
                  skid_d  = in_data;
`endif
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
`endif
            default: begin
               state_d = EMPTY;
               main_d  = '0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   assign in_ready_d = (state_d != TWO);
`endif

   // ---- state registers ----
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= EMPTY;
         main_q     <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_q     <= '0;
         in_ready_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
`ifdef PIPE_STAGE_SKID_EN
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_stage_reg. A queue holds the payloads the stage should
// currently own; expected outputs are derived from that queue each cycle.
// Follows PIPE_STAGE_SKID_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
   localparam int W = 64;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] mq[$];

   pipe_stage_reg #(.WIDTH(W)) dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   initial forever #5 CLK = ~CLK;

   // Expected ready given the entries currently held.
   function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || out_ready;
`endif
   endfunction

   function automatic logic [W-1:0] exp_data();
      return (mq.size() > 0) ? mq[0] : '0;
   endfunction

   // Advance one rising edge, update the model from the inputs seen there.
   task automatic tick();
      logic ir;
      logic psh, pp;
      @(posedge CLK);
      ir  = exp_ready();
      psh = in_valid && ir;
      pp  = (mq.size() > 0) && out_ready;
      if (nRST) begin
         if (flush) mq.delete();
         else begin
            if (pp) void'(mq.pop_front());
            if (psh) mq.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      mq.delete();
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_stream();
      logic [W-1:0] vals [3];
      vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         tick();
         n_cmp++; if (out_data !== vals[i] || out_data !== exp_data()) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, vals[i]); end
         n_cmp++; if (occupancy !== 2'd1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_occ[%0d]: got occ %0d valid %b want 1 1", i, occupancy, out_valid); end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'(mq.size())) begin n_bad++; $display("FAIL stream_drain: got valid %b occ %0d want 0 0", out_valid, occupancy); end
   endtask

`ifdef PIPE_STAGE_SKID_EN
   task automatic test_skid_fill();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA;
      tick();
      n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL fill_occ1: got %0d want 1", occupancy); end
      in_data = 64'hB;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL fill_occ2: got %0d want 2", occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_data !== 64'hA) begin n_bad++; $display("FAIL fill_hold: got %h want a", out_data); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (out_data !== 64'hA) begin n_bad++; $display("FAIL drain_first: got %h want a", out_data); end
      tick();
      n_cmp++; if (out_data !== 64'hB || in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_second: got %h rdy %b want b 1", out_data, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL drain_empty: got valid %b data %h want 0 0", out_valid, out_data); end
   endtask
`else
   task automatic test_noskid_ready();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA;
      tick();
      in_valid = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL noskid_stall_ready: got %b want 0", in_ready); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL noskid_pass_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_data !== 64'hA) begin n_bad++; $display("FAIL noskid_hold: got %h want a", out_data); end
      in_valid = 1'b1; in_data = 64'h5;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_data !== 64'h5 || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_bad++; $display("FAIL noskid_replace: got %h v%b occ %0d want 5 1 1", out_data, out_valid, occupancy); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL noskid_empty: got %b want 0", out_valid); end
   endtask
`endif

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA;
      tick();
`ifdef PIPE_STAGE_SKID_EN
      in_data = 64'hB;
      tick();
`else
      out_ready = 1'b1;   // push would be accepted if not for the flush
`endif
      in_data = 64'hC; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL flush_out: got valid %b data %h want 0 0", out_valid, out_data); end
      n_cmp++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state: got occ %0d rdy %b want 0 1", occupancy, in_ready); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0 || out_data === 64'hC) begin n_bad++; $display("FAIL flush_ghost[%0d]: got valid %b data %h want 0", i, out_valid, out_data); end
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA;
      tick();
      in_data = 64'hB;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'(mq.size())) begin n_bad++; $display("FAIL areset_pre_occ: got %0d want %0d", occupancy, mq.size()); end
      #1 nRST = 1'b0;
      mq.delete();
      #1;
      n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL areset_out: got valid %b data %h want 0 0", out_valid, out_data); end
      n_cmp++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_state: got occ %0d rdy %b want 0 1", occupancy, in_ready); end
      #2 nRST = 1'b1;
   endtask

   task automatic test_random();
      int bad_prints = 0;
      logic         hold;
      logic [W-1:0] held;
      int           pushes = 0;
      hold = 1'b0; held = '0;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         flush     = ($urandom_range(0, 63) == 0);
         in_data   = {$urandom, $urandom};
         #1;
         n_cmp++;
         if (out_valid !== (mq.size() > 0) || out_data !== exp_data() ||
             in_ready !== exp_ready() || occupancy !== 2'(mq.size())) begin
            n_bad++;
            if (bad_prints < 20) begin
               bad_prints++;
               $display("FAIL random[%0d]: got v%b d%h r%b o%0d want v%b d%h r%b o%0d", c,
                        out_valid, out_data, in_ready, occupancy,
                        (mq.size() > 0), exp_data(), exp_ready(), mq.size());
            end
         end
         if (hold) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_bad++;
               if (bad_prints < 20) begin
                  bad_prints++;
                  $display("FAIL stable[%0d]: got v%b d%h want v1 d%h", c, out_valid, out_data, held);
               end
            end
         end
         hold = out_valid && !out_ready && !flush;
         held = out_data;
         if (in_valid && exp_ready() && !flush) pushes++;
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (pushes < 1000) begin n_bad++; $display("FAIL random_activity: got %0d pushes want >= 1000", pushes); end
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL random_drain: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
`ifdef PIPE_STAGE_SKID_EN
      test_skid_fill();
`else
      test_noskid_ready();
`endif
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
